demux_feed_sequencer: RTL
=========================

Name: demux_feed_sequencer

Overview:
Upstream stage that drives the 1-to-4 demultiplexer's Xin and S inputs.
- Accepts a parallel word plus a target channel over a valid/ready handshake.
- Holds S at the target channel for the whole frame and serializes the word MSB-first onto Xin, each bit held for BIT_DIV clocks.
- Inserts an idle gap (Xin=0) between frames so downstream channel outputs settle low before S changes.

Parameters:
DATA_W, 8, bits per frame (>=1)
BIT_DIV, 4, clocks each bit is held on Xin (>=1)
GAP_CYC, 2, idle clocks after last bit before next accept is possible (>=0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream word/channel valid
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  word to serialize
in_chan  input  2  target demux channel
Xin  output  1  serial data to demux data input
S  output  2  channel select to demux
busy  output  1  frame in progress (SHIFT or GAP)
frame_done  output  1  one-cycle pulse when a frame fully completes

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- All outputs are registered.
- Reset values: Xin=0, S=2'b00, in_ready=1, busy=0, frame_done=0, state=IDLE, all counters 0.
- States:
  - IDLE: in_ready=1, busy=0, Xin=0, S holds its last value.
  - SHIFT: in_ready=0, busy=1, Xin=shreg[DATA_W-1].
  - GAP: in_ready=0, busy=1, Xin=0, S held.
- Accept: occurs on an edge where in_valid & in_ready. At that edge:
  - shreg<=in_data, S<=in_chan, div_cnt<=0, bit_cnt<=0, state<=SHIFT.
  - The first bit appears on Xin in the cycle immediately after the accept edge.
- SHIFT timing:
  - div_cnt counts 0..BIT_DIV-1.
  - When div_cnt==BIT_DIV-1: shreg shifts left by 1 (zero fill), div_cnt<=0, bit_cnt++.
  - When bit_cnt==DATA_W-1 && div_cnt==BIT_DIV-1: go to GAP (GAP_CYC>0) or IDLE (GAP_CYC==0).
- GAP: gap_cnt counts GAP_CYC cycles, then state<=IDLE.
- frame_done: high for exactly one cycle, the first cycle back in IDLE.
- Latency (accept at edge k):
  - Bit i occupies cycles k+i*BIT_DIV+1 .. k+(i+1)*BIT_DIV.
  - in_ready returns high after edge k+DATA_W*BIT_DIV+GAP_CYC.
  - Minimum accept-to-accept period is DATA_W*BIT_DIV+GAP_CYC+1 clocks.
- S stability: S changes only on an accept edge, never mid-frame or in GAP.
- Busy period: in_valid, in_data and in_chan are ignored while in_ready=0. Upstream must hold in_valid until accepted.
- Back-to-back: if in_valid is held high, the next word is accepted on the first IDLE cycle's edge, the same cycle frame_done is high.
- BIT_DIV=1: shift every clock. GAP_CYC=0: go directly SHIFT->IDLE.
- Counter widths: $clog2 sized, minimum 1 bit. No wrap-around beyond terminal counts.
- Reset mid-frame: on any edge with rst=1, the frame is aborted and all outputs take reset values in the next cycle. No frame_done is issued and no partial data is retained.
- rst has priority over a simultaneous accept.

Test Plan:
1. Reset: rst=1 for 2 clocks -> Xin=0, S=00, in_ready=1, busy=0, frame_done=0.
2. Single frame, defaults, 0xA5 on chan 2 accepted at edge k -> S=10 from cycle k+1; Xin=1,0,1,0,0,1,0,1, each held 4 cycles (k+1..k+32); Xin=0 for k+33..k+34; frame_done=1 and in_ready=1 in cycle k+35 only.
3. Back-to-back: in_valid held high with 0xFF/chan1, then 0x01/chan3 -> second accept exactly 35 clocks after first; S goes 01->11 only at second accept edge; Xin stays high for 32 cycles, then low for 31 cycles, then high for 4.
4. Busy-period stimulus: during frame of 0x3C/chan0, toggle in_data=0xFF and in_chan=3 with in_valid=1 -> Xin sequence stays 0,0,1,1,1,1,0,0 (x4 cycles each); S stays 00 until the pending word is accepted in IDLE.
5. Reset mid-frame: assert rst during bit 3 of 0xF0/chan1 -> next cycle Xin=0, S=00, in_ready=1, busy=0; frame_done never pulses.
6. BIT_DIV=1, GAP_CYC=0 build: 0x80/chan3 -> Xin=1 for 1 cycle then 0 for 7; in_ready and frame_done high 9 cycles after accept edge.

Source files
------------

// File: rtl/demux_feed_sequencer.sv
// Feeds a 1-to-4 demux: holds S on the target channel for a whole frame,
// shifts the word out MSB-first on Xin (BIT_DIV clocks per bit), then idles for GAP_CYC clocks.
module demux_feed_sequencer #(
    parameter int DATA_W  = 8,
    parameter int BIT_DIV = 4,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_chan,
    output logic              Xin,
    output logic [1:0]        S,
    output logic              busy,
    output logic              frame_done
);

    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              xin_q, xin_d;
    logic [1:0]        s_q, s_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    shreg_d = in_data;
                    s_d     = in_chan;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    shreg_d = shreg_q << 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        gap_d   = '0;
                        state_d = (GAP_CYC > 0) ? GAP : IDLE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are precomputed from the next state so they come straight off flops.
        xin_d   = (state_d == SHIFT) && shreg_d[DATA_W-1];
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q != IDLE) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            xin_q   <= 1'b0;
            s_q     <= 2'b00;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            xin_q   <= xin_d;
            s_q     <= s_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Xin        = xin_q;
    assign S          = s_q;
    assign in_ready   = ready_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
